// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// mult/div default latency, register-zero constant and operand-match helper.
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hz_state_e;

  localparam int unsigned MD_CYCLES_DEFAULT = 32;
  localparam logic [4:0]  REG_ZERO          = 5'b00000;

  // True when r is a real register that the ID instruction actually reads.
  function automatic logic src_match(
    input logic [4:0] r,
    input logic [4:0] rs,
    input logic       uses_rs,
    input logic [4:0] rt,
    input logic       uses_rt
  );
    return (r != REG_ZERO) && ((uses_rs && (r == rs)) || (uses_rt && (r == rt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_timer.sv
// Loadable down-counter with enable; flags when the count has reached zero.
module md_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller: per-stage stall/flush generation
// for load-use, branch-operand, mult/div occupancy, memory wait and exceptions.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_CYCLES = MD_CYCLES_DEFAULT,
  parameter int unsigned CNT_W     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_Rs,
  input  logic [4:0] id_Rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_is_branch,
  input  logic [4:0] ex_wreg,
  input  logic       ex_RegWrite,
  input  logic       ex_MemRead,
  input  logic       ex_md_start,
  input  logic [4:0] mem_wreg,
  input  logic       mem_MemRead,
  input  logic       mem_stall,
  input  logic       exc_req,
  output logic       stall_pc,
  output logic       stall_if_id,
  output logic       stall_id_ex,
  output logic       stall_ex_mem,
  output logic       flush_if_id,
  output logic       flush_id_ex,
  output logic       flush_ex_mem,
  output logic       flush_mem_wb,
  output logic       md_busy,
  output logic       md_result_valid,
  output logic       exc_redirect
);

  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 1);

  hz_state_e        state;
  hz_state_e        state_next;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_en;
  logic             cnt_zero;
  logic             ex_match;
  logic             mem_match;
  logic             branch_hz;
  logic             load_use;

  md_timer #(.CNT_W(CNT_W)) u_md_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .zero     (cnt_zero)
  );

  assign ex_match  = src_match(ex_wreg,  id_Rs, id_uses_rs, id_Rt, id_uses_rt);
  assign mem_match = src_match(mem_wreg, id_Rs, id_uses_rs, id_Rt, id_uses_rt);
  assign branch_hz = id_is_branch && ((ex_RegWrite && ex_match) || (mem_MemRead && mem_match));
  assign load_use  = ex_MemRead && ex_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Exception reloads the timer with zero so an aborted mult/div leaves no residue.
  always_comb begin
    state_next   = state;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_en       = 1'b0;
    if (exc_req) begin
      state_next = RUN;
      tmr_load   = 1'b1;
    end else if (mem_stall) begin
      state_next = state;
    end else if (state == MD_BUSY) begin
      if (!cnt_zero) begin
        tmr_en = 1'b1;
      end else begin
        state_next = RUN;
      end
    end else if (ex_md_start) begin
      state_next   = MD_BUSY;
      tmr_load     = 1'b1;
      tmr_load_val = MD_LOAD;
    end
  end

  always_comb begin
    stall_pc        = 1'b0;
    stall_if_id     = 1'b0;
    stall_id_ex     = 1'b0;
    stall_ex_mem    = 1'b0;
    flush_if_id     = 1'b0;
    flush_id_ex     = 1'b0;
    flush_ex_mem    = 1'b0;
    flush_mem_wb    = 1'b0;
    md_busy         = 1'b0;
    md_result_valid = 1'b0;
    exc_redirect    = 1'b0;
    if (!rst) begin
      if (exc_req) begin
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
        flush_mem_wb = 1'b1;
        exc_redirect = 1'b1;
      end else if (mem_stall) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
        flush_mem_wb = 1'b1;
        md_busy      = (state == MD_BUSY);
      end else if (state == MD_BUSY) begin
        if (!cnt_zero) begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          stall_id_ex  = 1'b1;
          stall_ex_mem = 1'b1;
          flush_mem_wb = 1'b1;
          md_busy      = 1'b1;
        end else begin
          md_result_valid = 1'b1;
        end
      end else if (ex_md_start) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
        flush_mem_wb = 1'b1;
        md_busy      = 1'b1;
      end else if (branch_hz || load_use) begin
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for the combinational interlocks
// plus hand-written multi-cycle sequences for mult/div, exceptions and reset.
module tb_hazard_ctrl;

  // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex,
  //  flush_ex_mem, flush_mem_wb, md_busy, md_result_valid, exc_redirect}
  localparam logic [10:0] NONE  = 11'b00000000000;
  localparam logic [10:0] IL    = 11'b11000100000;
  localparam logic [10:0] MEMW  = 11'b11110001000;
  localparam logic [10:0] MDST  = 11'b11110001100;
  localparam logic [10:0] EXC   = 11'b00001111001;
  localparam logic [10:0] VALID = 11'b00000000010;

  typedef struct {
    logic [4:0]  rs, rt;
    logic        urs, urt, br;
    logic [4:0]  exw;
    logic        exrw, exmr;
    logic [4:0]  memw;
    logic        memmr, mstall, exc;
    logic [10:0] exp;
  } vec_t;

  logic clk, rst;
  logic [4:0] id_Rs, id_Rt, ex_wreg, mem_wreg;
  logic id_uses_rs, id_uses_rt, id_is_branch, ex_RegWrite, ex_MemRead, ex_md_start;
  logic mem_MemRead, mem_stall, exc_req, md_start1;

  logic s_pc0, s_ifid0, s_idex0, s_exmem0, f_ifid0, f_idex0, f_exmem0, f_memwb0, busy0, valid0, redir0;
  logic s_pc1, s_ifid1, s_idex1, s_exmem1, f_ifid1, f_idex1, f_exmem1, f_memwb1, busy1, valid1, redir1;
  logic [10:0] o0, o1;

  int nvec = 0;
  int nerr = 0;

  assign o0 = {s_pc0, s_ifid0, s_idex0, s_exmem0, f_ifid0, f_idex0, f_exmem0, f_memwb0, busy0, valid0, redir0};
  assign o1 = {s_pc1, s_ifid1, s_idex1, s_exmem1, f_ifid1, f_idex1, f_exmem1, f_memwb1, busy1, valid1, redir1};

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_Rs(id_Rs), .id_Rt(id_Rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch), .ex_wreg(ex_wreg),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_md_start(ex_md_start),
    .mem_wreg(mem_wreg), .mem_MemRead(mem_MemRead), .mem_stall(mem_stall), .exc_req(exc_req),
    .stall_pc(s_pc0), .stall_if_id(s_ifid0), .stall_id_ex(s_idex0), .stall_ex_mem(s_exmem0),
    .flush_if_id(f_ifid0), .flush_id_ex(f_idex0), .flush_ex_mem(f_exmem0), .flush_mem_wb(f_memwb0),
    .md_busy(busy0), .md_result_valid(valid0), .exc_redirect(redir0)
  );

  hazard_ctrl #(.MD_CYCLES(1), .CNT_W(6)) dut1 (
    .clk(clk), .rst(rst), .id_Rs(id_Rs), .id_Rt(id_Rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch), .ex_wreg(ex_wreg),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_md_start(md_start1),
    .mem_wreg(mem_wreg), .mem_MemRead(mem_MemRead), .mem_stall(mem_stall), .exc_req(exc_req),
    .stall_pc(s_pc1), .stall_if_id(s_ifid1), .stall_id_ex(s_idex1), .stall_ex_mem(s_exmem1),
    .flush_if_id(f_ifid1), .flush_id_ex(f_idex1), .flush_ex_mem(f_exmem1), .flush_mem_wb(f_memwb1),
    .md_busy(busy1), .md_result_valid(valid1), .exc_redirect(redir1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(int rs, int rt, int urs, int urt, int br, int exw, int exrw,
                              int exmr, int memw, int memmr, int mst, int exc, logic [10:0] exp);
    vec_t v;
    v.rs = 5'(rs);       v.rt = 5'(rt);
    v.urs = urs[0];      v.urt = urt[0];      v.br = br[0];
    v.exw = 5'(exw);     v.exrw = exrw[0];    v.exmr = exmr[0];
    v.memw = 5'(memw);   v.memmr = memmr[0];  v.mstall = mst[0];
    v.exc = exc[0];      v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [10:0] got, input logic [10:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_Rs = '0; id_Rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_is_branch = 1'b0;
    ex_wreg = '0; ex_RegWrite = 1'b0; ex_MemRead = 1'b0; ex_md_start = 1'b0;
    mem_wreg = '0; mem_MemRead = 1'b0; mem_stall = 1'b0; exc_req = 1'b0;
  endtask

  vec_t tbl[15];
  int bubbles;
  int vcount;

  initial begin
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
    tbl[1]  = mk(8, 0, 1, 0, 0, 8, 1, 1, 0, 0, 0, 0, IL);    // load-use on Rs
    tbl[2]  = mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, NONE);  // $zero never interlocks
    tbl[3]  = mk(0, 8, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0, NONE);  // Rt matches but unused
    tbl[4]  = mk(0, 8, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0, IL);
    tbl[5]  = mk(5, 0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, NONE);  // ALU result: forwarded
    tbl[6]  = mk(0, 5, 0, 1, 1, 5, 1, 0, 0, 0, 0, 0, IL);    // branch vs EX write
    tbl[7]  = mk(7, 0, 1, 0, 1, 0, 0, 0, 7, 1, 0, 0, IL);    // branch vs MEM load
    tbl[8]  = mk(7, 0, 1, 0, 1, 0, 0, 0, 7, 0, 0, 0, NONE);
    tbl[9]  = mk(0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0, NONE);
    tbl[10] = mk(8, 0, 1, 0, 0, 8, 1, 1, 0, 0, 1, 0, MEMW);
    tbl[11] = mk(8, 0, 1, 0, 1, 8, 1, 1, 0, 0, 1, 1, EXC);
    tbl[12] = mk(7, 0, 1, 0, 0, 0, 0, 0, 7, 1, 0, 0, NONE);
    tbl[13] = mk(8, 0, 1, 0, 0, 9, 1, 1, 0, 0, 0, 0, NONE);
    tbl[14] = mk(3, 4, 1, 1, 1, 4, 1, 0, 0, 0, 0, 0, IL);

    idle();
    md_start1 = 1'b0;
    rst = 1'b1;
    cyc();
    chk("reset_idle", o0, NONE);
    exc_req = 1'b1; mem_stall = 1'b1; ex_md_start = 1'b1; md_start1 = 1'b1;
    #1;
    chk("reset_forced", o0, NONE);
    chk("reset_forced_md1", o1, NONE);
    idle();
    md_start1 = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 15; i++) begin
      id_Rs = tbl[i].rs; id_Rt = tbl[i].rt; id_uses_rs = tbl[i].urs; id_uses_rt = tbl[i].urt;
      id_is_branch = tbl[i].br; ex_wreg = tbl[i].exw; ex_RegWrite = tbl[i].exrw;
      ex_MemRead = tbl[i].exmr; mem_wreg = tbl[i].memw; mem_MemRead = tbl[i].memmr;
      mem_stall = tbl[i].mstall; exc_req = tbl[i].exc;
      #1;
      chk($sformatf("vec%0d", i), o0, tbl[i].exp);
      cyc();
    end
    idle();
    cyc();

    // load-use: one bubble, then the load sits in MEM and is forwarded
    id_Rs = 5'd8; id_uses_rs = 1'b1; ex_wreg = 5'd8; ex_RegWrite = 1'b1; ex_MemRead = 1'b1;
    #1 chk("lu_stall", o0, IL);
    cyc();
    ex_wreg = '0; ex_RegWrite = 1'b0; ex_MemRead = 1'b0; mem_wreg = 5'd8; mem_MemRead = 1'b1;
    #1 chk("lu_release", o0, NONE);
    idle();
    cyc();

    // branch waiting on an EX load: two bubbles
    bubbles = 0;
    id_is_branch = 1'b1; id_Rt = 5'd5; id_uses_rt = 1'b1;
    ex_wreg = 5'd5; ex_RegWrite = 1'b1; ex_MemRead = 1'b1;
    #1 if (o0 == IL) bubbles++;
    cyc();
    ex_wreg = '0; ex_RegWrite = 1'b0; ex_MemRead = 1'b0; mem_wreg = 5'd5; mem_MemRead = 1'b1;
    #1 if (o0 == IL) bubbles++;
    cyc();
    mem_wreg = '0; mem_MemRead = 1'b0;
    #1 chk("br_release", o0, NONE);
    chk("br_bubbles", 11'(bubbles), 11'd2);
    idle();
    cyc();

    // mult/div, default 32 cycles; ex_md_start stays high until the result edge
    ex_md_start = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      #1 chk($sformatf("md_c%0d", i), o0, (i < 32) ? MDST : VALID);
      cyc();
    end
    ex_md_start = 1'b0;
    #1 chk("md_after", o0, NONE);
    cyc();

    // mult/div with 3 memory-wait cycles in the middle
    ex_md_start = 1'b1;
    for (int i = 0; i <= 35; i++) begin
      mem_stall = (i >= 10 && i <= 12);
      #1 chk($sformatf("mdw_c%0d", i), o0, (i < 35) ? MDST : VALID);
      cyc();
    end
    ex_md_start = 1'b0;
    mem_stall = 1'b0;
    #1 chk("mdw_after", o0, NONE);
    cyc();

    // exception at cycle 10 of a mult/div
    ex_md_start = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    exc_req = 1'b1;
    #1 chk("exc_flush", o0, EXC);
    cyc();
    exc_req = 1'b0; ex_md_start = 1'b0;
    #1 chk("exc_next_run", o0, NONE);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid0 || busy0) vcount++;
      cyc();
    end
    chk("exc_no_result", 11'(vcount), 11'd0);

    // exception coincident with ex_md_start
    ex_md_start = 1'b1; exc_req = 1'b1;
    #1 chk("exc_vs_start", o0, EXC);
    cyc();
    ex_md_start = 1'b0; exc_req = 1'b0;
    #1 chk("exc_vs_start_next", o0, NONE);
    cyc();

    // reset mid mult/div, then a fresh start
    ex_md_start = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    rst = 1'b1;
    #1 chk("rst_mid", o0, NONE);
    cyc();
    chk("rst_held", o0, NONE);
    rst = 1'b0;
    for (int i = 0; i <= 32; i++) begin
      #1 chk($sformatf("rst_md_c%0d", i), o0, (i < 32) ? MDST : VALID);
      cyc();
    end
    ex_md_start = 1'b0;
    cyc();

    // MD_CYCLES = 1 instance
    md_start1 = 1'b1;
    #1 chk("md1_stall", o1, MDST);
    cyc();
    chk("md1_valid", o1, VALID);
    cyc();
    md_start1 = 1'b0;
    #1 chk("md1_after", o1, NONE);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
